serial_word_packer: RTL and testbench
=====================================

# serial_word_packer

Upstream framing stage for the two-entry write-only FIFO. It receives a one-bit serial stream and assembles each DATA_WIDTH-bit word MSB-first. It checks an even-parity bit that trails each word. Good words go to the FIFO as a one-cycle write pulse with the word; bad or overflowing words are dropped and counted.

## Interface
- DATA_WIDTH, 8, word width in bits (≥2)
- CNT_WIDTH, 16, width of the saturating statistics counters
- DROP_ON_FULL, 1, 1: suppress the write when fifo_full=1; 0: write regardless (FIFO overwrites its oldest entry)

Ports:
- clk  in  1  clock; all logic is rising-edge
- resetn  in  1  reset; synchronous, active-low
- sin  in  1  serial data bit
- sin_valid  in  1  sin is sampled on this cycle's edge only when this is 1
- sof  in  1  start of frame; qualified by sin_valid; marks the current bit as data bit DATA_WIDTH-1 of a new word
- fifo_full  in  1  full flag from the downstream FIFO
- din_o  out  DATA_WIDTH  assembled word; drives the FIFO din input
- wr_o  out  1  one-cycle write strobe to the FIFO
- parity_err  out  1  one-cycle pulse for each word that fails parity
- overflow  out  1  one-cycle pulse for each word dropped because fifo_full=1 (DROP_ON_FULL=1 only)
- busy  out  1  1 while a word is partially received (state DATA or PARITY)
- good_cnt  out  CNT_WIDTH  count of words written; saturates at all-ones
- err_cnt  out  CNT_WIDTH  count of parity errors plus overflows; saturates at all-ones

## Operation
- States: IDLE, DATA, PARITY. Reset state is IDLE.
- Reset values: din_o=0, wr_o=0, parity_err=0, overflow=0, busy=0, good_cnt=0, err_cnt=0. Shift register and bit counter are also cleared.
- A reset asserted mid-word discards the partial word. No strobe is emitted.
- Cycles with sin_valid=0 change no state or data. The strobes still deassert.
- IDLE:
  - Valid bits without sof are ignored.
  - sof&sin_valid loads the bit as the MSB, sets bit count to 1, and moves to DATA.
- DATA:
  - Each valid bit shifts in at the LSB, so the first bit ends up as the MSB.
  - When the bit count reaches DATA_WIDTH, move to PARITY.
  - sof&sin_valid aborts the partial word silently (no error, no count) and restarts with this bit as the MSB at count 1.
- PARITY: the valid bit is the parity bit p.
  - Check: XOR of the DATA_WIDTH data bits and p must equal 0 (even parity).
  - Pass with fifo_full=0, or pass with DROP_ON_FULL=0: din_o takes the word, wr_o pulses, good_cnt increments.
  - Pass with fifo_full=1 and DROP_ON_FULL=1: din_o is unchanged, overflow pulses, err_cnt increments.
  - Fail: din_o is unchanged, parity_err pulses, err_cnt increments. The parity result takes priority over the full check.
  - After the check, move to DATA with bit count 0. The next word follows back-to-back without sof.
  - sof asserted on the parity cycle is ignored: the bit is still treated as parity and the check still runs.
- fifo_full is sampled on the same edge as the parity bit.
- din_o holds its value between writes.
- Counters saturate: at all-ones they hold and never wrap.

## Timing
- Latency: wr_o, parity_err and overflow are registered. Each is high for exactly the one cycle after the edge that sampled the parity bit. din_o is valid on that same cycle.
- Back-to-back frames with sin_valid held at 1 produce at most one strobe every DATA_WIDTH+1 cycles.
- busy goes to 1 on the cycle after a sof is accepted. It goes to 0 only on reset. After the first frame, busy stays 1 because the block waits in DATA for the next word.
- No combinational path runs from any input to any output.

## Test plan
- Clean word, DATA_WIDTH=8, sin_valid=1, fifo_full=0: sof + bits 1,0,1,0,0,1,0,1 + p=0 → one cycle later din_o=0xA5 and wr_o=1 for 1 cycle; good_cnt=1.
- Parity fail: bits for 0xA5 + p=1 → parity_err=1 for 1 cycle; wr_o stays 0; din_o keeps its previous value; err_cnt=1.
- Gapped stream: send 0x3C (p=0) with sin_valid=0 for 3 cycles between every bit → din_o=0x3C; wr_o pulses exactly once, on the cycle after the parity bit.
- Abort and back-to-back:
  - Send 5 bits, then sof followed by 0xFF, p=0 → only 0xFF is written.
  - Then send 0x01, p=1 with no sof → second write of din_o=0x01.
- Full handling:
  - fifo_full=1, DROP_ON_FULL=1, word 0x0F p=0 → overflow pulse, no wr_o, err_cnt increments.
  - Same stimulus with DROP_ON_FULL=0 → wr_o pulses and din_o=0x0F.
- Reset and saturation:
  - Drop resetn for 1 cycle mid-word → all outputs return to 0 and the state is IDLE; bits sent without sof are then ignored.
  - With CNT_WIDTH=2, send 5 good words → good_cnt holds at 3.

Source files
------------

// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - MSB-first serial-to-word packer with even-parity check and FIFO write strobe
module serial_word_packer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CNT_WIDTH    = 16,
    parameter int DROP_ON_FULL = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sin,
    input  logic                  sin_valid,
    input  logic                  sof,
    input  logic                  fifo_full,
    output logic [DATA_WIDTH-1:0] din_o,
    output logic                  wr_o,
    output logic                  parity_err,
    output logic                  overflow,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [BW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic                  perr_q, perr_d;
    logic                  ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]  good_q, good_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic                  parity_ok;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            shift_q <= '0;
            din_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            good_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            perr_q  <= perr_d;
            ovf_q   <= ovf_d;
            good_q  <= good_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        din_d     = din_q;
        cnt_d     = cnt_q;
        wr_d      = 1'b0;
        perr_d    = 1'b0;
        ovf_d     = 1'b0;
        good_d    = good_q;
        err_d     = err_q;
        parity_ok = ~(^shift_q ^ sin);

        if (sin_valid) begin
            case (state_q)
                IDLE: begin
                    if (sof) begin
                        shift_d = {{(DATA_WIDTH-1){1'b0}}, sin};
                        cnt_d   = BW'(1);
                        state_d = DATA;
                    end
                end
                DATA: begin
                    // sof mid-word silently discards the partial word and restarts
                    if (sof) begin
                        shift_d = {{(DATA_WIDTH-1){1'b0}}, sin};
                        cnt_d   = BW'(1);
                    end else begin
                        shift_d = {shift_q[DATA_WIDTH-2:0], sin};
                        cnt_d   = cnt_q + BW'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = PARITY;
                        end
                    end
                end
                PARITY: begin
                    // parity bit; sof is ignored here and the next word follows without one
                    cnt_d   = '0;
                    state_d = DATA;
                    if (!parity_ok) begin
                        perr_d = 1'b1;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end else if ((DROP_ON_FULL != 0) && fifo_full) begin
                        ovf_d = 1'b1;
                        if (err_q != '1) err_d = err_q + 1'b1;
                    end else begin
                        din_d = shift_q;
                        wr_d  = 1'b1;
                        if (good_q != '1) good_d = good_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign din_o      = din_q;
    assign wr_o       = wr_q;
    assign parity_err = perr_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE);
    assign good_cnt   = good_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - directed scoreboard bench for serial_word_packer
module tb_serial_word_packer;

    logic clk = 1'b0;
    logic resetn, sin, sin_valid, sof, fifo_full;

    logic [7:0]  din_o, nd_din;
    logic        wr_o, parity_err, overflow, busy;
    logic        nd_wr, nd_perr, nd_ovf, nd_busy;
    logic [15:0] good_cnt, err_cnt, nd_good_cnt, nd_err_cnt;
    logic [7:0]  sat_din;
    logic        sat_wr, sat_perr, sat_ovf, sat_busy;
    logic [1:0]  sat_good_cnt, sat_err_cnt;

    serial_word_packer #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ON_FULL(1)) dut (
        .clk(clk), .resetn(resetn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .fifo_full(fifo_full), .din_o(din_o), .wr_o(wr_o), .parity_err(parity_err),
        .overflow(overflow), .busy(busy), .good_cnt(good_cnt), .err_cnt(err_cnt)
    );

    serial_word_packer #(.DATA_WIDTH(8), .CNT_WIDTH(16), .DROP_ON_FULL(0)) dut_nd (
        .clk(clk), .resetn(resetn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .fifo_full(fifo_full), .din_o(nd_din), .wr_o(nd_wr), .parity_err(nd_perr),
        .overflow(nd_ovf), .busy(nd_busy), .good_cnt(nd_good_cnt), .err_cnt(nd_err_cnt)
    );

    serial_word_packer #(.DATA_WIDTH(8), .CNT_WIDTH(2), .DROP_ON_FULL(1)) dut_sat (
        .clk(clk), .resetn(resetn), .sin(sin), .sin_valid(sin_valid), .sof(sof),
        .fifo_full(fifo_full), .din_o(sat_din), .wr_o(sat_wr), .parity_err(sat_perr),
        .overflow(sat_ovf), .busy(sat_busy), .good_cnt(sat_good_cnt), .err_cnt(sat_err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_good = 0, exp_err = 0, nd_good = 0, nd_err = 0;
    logic [7:0] q_main[$];
    logic [7:0] q_nd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest expected word
    always @(negedge clk) begin : mon_main
        logic [7:0] e;
        if (wr_o === 1'b1) begin
            if (q_main.size() == 0) chk("main_unexpected_wr", 32'(wr_o), 32'd0);
            else begin
                e = q_main.pop_front();
                chk("main_din", 32'(din_o), 32'(e));
            end
        end
    end

    always @(negedge clk) begin : mon_nd
        logic [7:0] e;
        if (nd_wr === 1'b1) begin
            if (q_nd.size() == 0) chk("nd_unexpected_wr", 32'(nd_wr), 32'd0);
            else begin
                e = q_nd.pop_front();
                chk("nd_din", 32'(nd_din), 32'(e));
            end
        end
    end

    task automatic send_bits(input logic [7:0] d, input int n, input bit do_sof, input int gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sin       = d[7-i];
            sin_valid = 1'b1;
            sof       = do_sof && (i == 0);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                sin_valid = 1'b0;
                sof       = 1'b0;
            end
        end
    endtask

    task automatic send_word(input string tag, input logic [7:0] d, input logic p,
                             input bit do_sof, input int gap);
        bit ok, ewr;
        ok  = ~(^{d, p});
        ewr = ok && !fifo_full;
        if (ewr) begin q_main.push_back(d); exp_good++; end
        else exp_err++;
        if (ok) begin q_nd.push_back(d); nd_good++; end
        else nd_err++;
        send_bits(d, 8, do_sof, gap);
        @(negedge clk);
        sin       = p;
        sin_valid = 1'b1;
        sof       = 1'b0;
        @(negedge clk);
        sin_valid = 1'b0;
        chk({tag, "_wr"},   32'(wr_o),       32'(ewr));
        chk({tag, "_perr"}, 32'(parity_err), 32'(!ok));
        chk({tag, "_ovf"},  32'(overflow),   32'(ok && fifo_full));
        chk({tag, "_nd_wr"}, 32'(nd_wr),     32'(ok));
        chk({tag, "_good"}, 32'(good_cnt),   32'(exp_good));
        chk({tag, "_err"},  32'(err_cnt),    32'(exp_err));
        @(negedge clk);
        chk({tag, "_strobes_low"}, {29'd0, wr_o, parity_err, overflow}, 32'd0);
    endtask

    initial begin
        resetn = 1'b0; sin = 1'b0; sin_valid = 1'b0; sof = 1'b0; fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_din",  32'(din_o), 32'd0);
        chk("rst_outs", {28'd0, wr_o, parity_err, overflow, busy}, 32'd0);
        chk("rst_good", 32'(good_cnt), 32'd0);
        chk("rst_err",  32'(err_cnt), 32'd0);
        resetn = 1'b1;

        // valid bits without sof in IDLE are ignored
        send_bits(8'hFF, 4, 1'b0, 0);
        @(negedge clk); sin_valid = 1'b0;
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        send_word("clean_a5", 8'hA5, 1'b0, 1'b1, 0);
        chk("clean_busy", 32'(busy), 32'd1);
        send_word("perr_a5", 8'hA5, 1'b1, 1'b1, 0);
        chk("perr_din_hold", 32'(din_o), 32'hA5);
        send_word("gap_3c", 8'h3C, 1'b0, 1'b1, 3);

        send_bits(8'b10110000, 5, 1'b1, 0);
        send_word("abort_ff", 8'hFF, 1'b0, 1'b1, 0);
        send_word("b2b_01", 8'h01, 1'b1, 1'b0, 0);

        @(negedge clk); fifo_full = 1'b1;
        send_word("full_0f", 8'h0F, 1'b0, 1'b1, 0);
        chk("full_din_hold", 32'(din_o), 32'h01);
        chk("full_nd_din", 32'(nd_din), 32'h0F);
        send_word("full_perr", 8'h0F, 1'b1, 1'b1, 0);
        chk("nd_err", 32'(nd_err_cnt), 32'(nd_err));
        chk("nd_good", 32'(nd_good_cnt), 32'(nd_good));
        fifo_full = 1'b0;

        send_bits(8'hA5, 3, 1'b1, 0);
        @(negedge clk); resetn = 1'b0; sin = 1'b1; sin_valid = 1'b1;
        @(negedge clk); resetn = 1'b1; sin_valid = 1'b0;
        exp_good = 0; exp_err = 0; nd_good = 0; nd_err = 0;
        chk("mid_rst_din",  32'(din_o), 32'd0);
        chk("mid_rst_outs", {28'd0, wr_o, parity_err, overflow, busy}, 32'd0);
        chk("mid_rst_cnts", {good_cnt, err_cnt}, 32'd0);
        send_bits(8'hA5, 8, 1'b0, 0);
        @(negedge clk); sin = 1'b0;
        @(negedge clk); sin_valid = 1'b0;
        @(negedge clk);
        chk("nosof_busy", 32'(busy), 32'd0);
        chk("nosof_good", 32'(good_cnt), 32'd0);

        for (int k = 0; k < 5; k++) send_word("sat", 8'h81, 1'b0, 1'b1, 0);
        chk("sat_good", 32'(sat_good_cnt), 32'd3);
        chk("sat_err",  32'(sat_err_cnt), 32'd0);
        chk("main_good_5", 32'(good_cnt), 32'd5);

        chk("q_main_empty", 32'(q_main.size()), 32'd0);
        chk("q_nd_empty",   32'(q_nd.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
